vga_scroll_ctrl: RTL
====================

# vga_scroll_ctrl

Frame-synchronous scroll controller for the 320×240 VGA frame buffer path. It produces the row offset that the pixel address generator adds to the scaled line index. It owns the offset register and changes it only at the start of vertical blanking, so a scroll step never tears a visible frame. It also sequences run/stop, scroll speed and direction, and one-shot seek-to-row requests from the game logic.

## Interface
- ROWS, 240, number of buffer rows; offset range 0..ROWS-1
- STEP_W, 4, width of step input
- DIV_W, 4, width of frame divider input
- clk  in  1  system clock; h_cnt/v_cnt may hold for several clk cycles
- rst  in  1  reset, asynchronous, active-high
- h_cnt  in  10  VGA horizontal counter, 0..799
- v_cnt  in  10  VGA vertical counter, 0..524
- start  in  1  single-cycle pulse; begin scrolling
- stop  in  1  single-cycle pulse; freeze offset
- dir  in  1  0 = offset increases (content moves up), 1 = offset decreases; latched on start
- step  in  STEP_W  rows per advance; latched on start
- frame_div  in  DIV_W  advance once every frame_div+1 frames; latched on start
- seek_req  in  1  level; request offset load
- seek_row  in  8  target row; captured when seek_req is accepted
- seek_ack  out  1  one-cycle pulse when the seek row is loaded
- offset  out  8  current row offset to address generator
- running  out  1  1 while in RUN
- frame_tick  out  1  one-cycle pulse, first cycle of new offset window

## Operation
- Frame boundary: cond = (v_cnt==480 && h_cnt==0). tick_i = cond && !cond_q, where cond_q is cond registered. Exactly one tick_i per frame regardless of clk/pixel ratio.
- States:
  - IDLE: offset held. start goes to RUN.
  - RUN: advance on divided ticks. stop goes to IDLE.
- Seek is an orthogonal pending flag, accepted in either state.
- start latches dir, step and frame_div, and clears div_cnt to 0. A start while already in RUN re-latches these values and restarts div_cnt.
- stop and start in the same cycle: stop wins.
- Divider: on each tick_i in RUN:
  - If div_cnt == frame_div, advance and set div_cnt to 0.
  - Otherwise div_cnt increments.
- Advance with wrap:
  - Increasing: n = offset + step; if n ≥ ROWS then n − ROWS.
  - Decreasing: if offset < step then offset + ROWS − step, else offset − step.
  - Intermediate arithmetic is 9 bits.
- step = 0: no motion, but ticks still counted.
- Seek:
  - When seek_req=1 and no seek is pending, capture seek_row and set pending. A seek_row ≥ ROWS is captured as ROWS−1.
  - While pending, further seek_req is ignored until seek_ack.
  - At the next tick_i, offset ← captured row and seek_ack pulses. The state is unchanged.
  - In RUN, div_cnt is cleared to 0.
- Seek and advance on the same tick: seek wins, no advance that frame.
- Reset mid-operation: all state clears immediately and any pending seek is dropped.

## Timing
- Reset values:
  - offset=0, running=0, seek_ack=0, frame_tick=0.
  - Internal state IDLE, div_cnt=0, pending=0, cond_q=0.
  - Latched dir=0, step=1, frame_div=0.
- Let T be the clk cycle where tick_i=1. offset, seek_ack and frame_tick all update at the edge ending cycle T. frame_tick is high during T+1, and the new offset is visible from T+1.
- running updates one edge after start/stop.
- Seek accepted at edge E (pending visible E+1). A seek_req high in the same cycle as tick_i is captured but loads at the following frame, not at this tick.
- offset changes only at tick edges or on reset. v_cnt 480..524 is blanking, so updates land ≥44 lines before the next visible row 0.

## Configuration
- VGA_SCROLL_WRAP_EN defined: wrap-around arithmetic as above (endless scroll).
- VGA_SCROLL_WRAP_EN undefined: ping-pong (bounce) mode.
  - Increasing: if offset + step > ROWS−1, offset = ROWS−1 and the internal direction flips.
  - Decreasing: if offset < step, offset = 0 and the direction flips.
  - Flipped direction persists until the next start re-latches dir.
  - Seek behaviour is identical in both modes.

## Test plan
- Reset then idle: rst pulse mid-frame, drive 3 frames with no start → offset=0, running=0, frame_tick pulses once per frame, exactly 1 cycle wide even with h_cnt held 4 clk per count.
- Basic scroll: start with dir=0, step=1, frame_div=0 → offset 1,2,3 on successive frames. Stop after frame 3 → offset stays 3 for 5 frames.
- Divider and wrap (WRAP_EN): offset=238, start with step=3, frame_div=2 → offset changes every 3rd frame to 1, then 4. With dir=1 from offset 1, step=3 → 238.
- Bounce (no WRAP_EN): offset=237, dir=0, step=5 → 239, then 234, then 229.
- Seek: in RUN, seek_req with seek_row=100 → offset=100 at next frame with seek_ack high 1 cycle, coinciding with frame_tick and no advance that frame. seek_row=250 → loads 239. A second seek_req while pending is ignored.
- Collisions: start and stop same cycle → stays IDLE. seek_req asserted in the tick cycle → loads at the following frame. rst asserted while seek is pending → no seek_ack ever, offset=0.

Source files
------------

// File: rtl/vga_scroll_ctrl.sv
// Frame-synchronous row-offset scroller for the 320x240 frame buffer path.
// Define VGA_SCROLL_WRAP_EN for endless wrap-around scrolling; default build bounces at the ends.
module vga_scroll_ctrl #(
    parameter int ROWS   = 240,
    parameter int STEP_W = 4,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [DIV_W-1:0]  frame_div,
    input  logic              seek_req,
    input  logic [7:0]        seek_row,
    output logic              seek_ack,
    output logic [7:0]        offset,
    output logic              running,
    output logic              frame_tick
);

    localparam logic [8:0] ROWS_9 = 9'(ROWS);
    localparam logic [8:0] LAST_9 = 9'(ROWS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                cond, cond_q, tick_i;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                pending_q, pending_d;
    logic [7:0]          seek_row_q, seek_row_d;
    logic [7:0]          offset_q, offset_d;
    logic                seek_ack_q, seek_ack_d;
    logic                frame_tick_q;

    logic [8:0]          base, step9, sum, adv;
    logic                adv_dir;

    // Edge-detect the start of blanking so a held h_cnt/v_cnt yields one tick.
    assign cond   = (v_cnt == 10'd480) && (h_cnt == 10'd0);
    assign tick_i = cond && !cond_q;

    // Next offset for one advance step, plus the direction that results.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        base    = {1'b0, offset_q};
        step9   = 9'(step_q);
        sum     = base + step9;
        adv     = base;
        adv_dir = dir_q;
`ifdef VGA_SCROLL_WRAP_EN
        if (!dir_q) begin
            adv = (sum >= ROWS_9) ? (sum - ROWS_9) : sum;
        end else begin
            adv = (base < step9) ? (base + ROWS_9 - step9) : (base - step9);
        end
`else
        if (!dir_q) begin
            if (sum > LAST_9) begin
                adv     = LAST_9;
                adv_dir = 1'b1;
            end else begin
                adv = sum;
            end
        end else begin
            if (base < step9) begin
                adv     = 9'd0;
                adv_dir = 1'b0;
            end else begin
                adv = base - step9;
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        step_d     = step_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        pending_d  = pending_q;
        seek_row_d = seek_row_q;
        offset_d   = offset_q;
        seek_ack_d = 1'b0;

        if (tick_i) begin
            if (pending_q) begin
                // A pending seek takes the frame; no advance this time.
                offset_d   = seek_row_q;
                seek_ack_d = 1'b1;
                pending_d  = 1'b0;
                if (state_q == S_RUN) begin
                    div_cnt_d = '0;
                end
            end else if (state_q == S_RUN) begin
                if (div_cnt_q == div_q) begin
                    div_cnt_d = '0;
                    offset_d  = adv[7:0];
                    dir_d     = adv_dir;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
        end

        // A request seen while one is still pending (including the load cycle) is dropped.
        if (seek_req && !pending_q) begin
            pending_d  = 1'b1;
            seek_row_d = ({1'b0, seek_row} >= ROWS_9) ? LAST_9[7:0] : seek_row;
        end

        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d   = S_RUN;
            dir_d     = dir;
            step_d    = step;
            div_d     = frame_div;
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cond_q       <= 1'b0;
            dir_q        <= 1'b0;
            step_q       <= STEP_W'(1);
            div_q        <= '0;
            div_cnt_q    <= '0;
            pending_q    <= 1'b0;
            seek_row_q   <= '0;
            offset_q     <= '0;
            seek_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            cond_q       <= cond;
            dir_q        <= dir_d;
            step_q       <= step_d;
            div_q        <= div_d;
            div_cnt_q    <= div_cnt_d;
            pending_q    <= pending_d;
            seek_row_q   <= seek_row_d;
            offset_q     <= offset_d;
            seek_ack_q   <= seek_ack_d;
            frame_tick_q <= tick_i;
        end
    end

    assign offset     = offset_q;
    assign running    = (state_q == S_RUN);
    assign seek_ack   = seek_ack_q;
    assign frame_tick = frame_tick_q;

endmodule
